pair_bus_tx: RTL and testbench

- Transmit end of the 10-bit pair-coded bus. Takes a 3-bit symbol over a valid/ready handshake and pair-encodes it onto the shared inout bus `a`.
- Optionally follows the true frame with a complement frame, then releases the bus for a turnaround gap.
- Reads the bus back while driving, to detect contention.
- Sits opposite the pair-bus receiver, which ANDs bit pairs, ORs them into `z` and registers `z`/`zbar`.

---
 rtl/pair_bus_tx.sv | 121 ++++++++++++
 tb/tb_pair_bus_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_bus_tx.sv
// Transmit end of the 10-bit pair-coded bus.
// Accepts a 3-bit symbol, drives enc(sym) and optionally enc(~sym), then releases the bus
// for a turnaround gap. The bus is read back at the end of each frame to flag contention.
module pair_bus_tx #(
  parameter int unsigned HOLD_CYCLES = 2,    // 1..15 cycles per frame
  parameter int unsigned TURN_CYCLES = 1,    // 1..15 cycles of released bus
  parameter bit          SEND_INV    = 1'b1  // follow true frame with complement frame
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sym,
  input  logic       sym_valid,
  output logic       sym_ready,
  inout  wire  [9:0] a,
  output logic       oe,
  output logic       busy,
  output logic       collision,
  output logic [7:0] frames_sent
);

  typedef enum logic [1:0] {StIdle, StData, StInv, StTurn} state_e;

  localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] TurnLoad = 4'(TURN_CYCLES - 1);

  state_e     r_state;
  logic [2:0] r_sym;
  logic [3:0] r_hold;
  logic [3:0] r_turn;
  logic       r_oe;
  logic [9:0] r_drv;
  logic       r_coll;
  logic [7:0] r_frames;
  logic [2:0] w_rb;

  // Each symbol bit is carried on a pair of lines; pairs 7:6 and 1:0 stay low.
  function automatic logic [9:0] enc(input logic [2:0] s);
    return {s[2], s[2], 2'b00, s[1], s[1], s[0], s[0], 2'b00};
  endfunction

  // Same reduction the receiver applies: AND each pair, OR neighbouring pairs.
  function automatic logic [2:0] dec(input logic [9:0] v);
    return {(v[9] & v[8]) | (v[7] & v[6]),
            (v[7] & v[6]) | (v[5] & v[4]),
            (v[3] & v[2]) | (v[1] & v[0])};
  endfunction

  assign a           = r_oe ? r_drv : 10'bzzzz_zzzz_zz;
  assign w_rb        = dec(a);
  assign oe          = r_oe;
  assign sym_ready   = (r_state == StIdle);
  assign busy        = (r_state != StIdle);
  assign collision   = r_coll;
  assign frames_sent = r_frames;

  // Frame sequencer with registered bus drive, readback compare and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_sym    <= 3'b000;
      r_hold   <= 4'd0;
      r_turn   <= 4'd0;
      r_oe     <= 1'b0;
      r_drv    <= 10'd0;
      r_coll   <= 1'b0;
      r_frames <= 8'd0;
    end else begin
      r_coll <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (sym_valid) begin
            r_sym   <= sym;
            r_hold  <= HoldLoad;
            r_oe    <= 1'b1;
            r_drv   <= enc(sym);
            r_state <= StData;
          end
        end
        StData: begin
          if (r_hold != 4'd0) begin
            r_hold <= r_hold - 4'd1;
          end else begin
            r_coll <= (w_rb != r_sym);
            if (SEND_INV) begin
              r_hold  <= HoldLoad;
              r_drv   <= enc(~r_sym);
              r_state <= StInv;
            end else begin
              r_turn   <= TurnLoad;
              r_oe     <= 1'b0;
              r_drv    <= 10'd0;
              r_frames <= r_frames + 8'd1;
              r_state  <= StTurn;
            end
          end
        end
        StInv: begin
          if (r_hold != 4'd0) begin
            r_hold <= r_hold - 4'd1;
          end else begin
            r_coll   <= (w_rb != ~r_sym);
            r_turn   <= TurnLoad;
            r_oe     <= 1'b0;
            r_drv    <= 10'd0;
            r_frames <= r_frames + 8'd1;
            r_state  <= StTurn;
          end
        end
        StTurn: begin
          if (r_turn != 4'd0) begin
            r_turn <= r_turn - 4'd1;
          end else begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_bus_tx.sv
// Bench for pair_bus_tx: a queue of expected per-cycle bus activity is built for every
// accepted symbol and compared with the DUT each cycle, plus directed frame/reset checks.
module tb_pair_bus_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sym = 3'd0;
  logic       sym_valid = 1'b0;
  logic       sym_ready, oe, busy, collision;
  logic [7:0] frames_sent;
  wire  [9:0] a;
  logic       jam = 1'b0;

  logic [2:0] sym2 = 3'd0;
  logic       sym_valid2 = 1'b0;
  logic       sym_ready2, oe2, busy2, collision2;
  logic [7:0] frames_sent2;
  wire  [9:0] a2;

  // Contending driver on the pair the transmitter always holds low.
  assign a[7:6] = jam ? 2'b11 : 2'bzz;

  pair_bus_tx u_dut (
    .clk(clk), .rst(rst), .sym(sym), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .a(a), .oe(oe), .busy(busy), .collision(collision), .frames_sent(frames_sent)
  );

  pair_bus_tx #(.HOLD_CYCLES(1), .TURN_CYCLES(1), .SEND_INV(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .sym(sym2), .sym_valid(sym_valid2), .sym_ready(sym_ready2),
    .a(a2), .oe(oe2), .busy(busy2), .collision(collision2), .frames_sent(frames_sent2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit         drv;   // bus driven this cycle
    logic [9:0] val;   // value driven
    bit         rb;    // readback point (last cycle of a frame)
    logic [2:0] want;  // symbol the readback must decode to
    bit         last;  // last driven cycle before turnaround
  } cyc_t;

  cyc_t       q[$];
  cyc_t       e;
  logic [7:0] exp_frames = 8'd0;
  bit         exp_coll = 1'b0;
  int         accepted = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         chk_en = 1'b0;
  bit         exp_oe;

  function automatic logic [9:0] enc(input logic [2:0] s);
    logic [9:0] v;
    v = 10'd0;
    v[9] = s[2]; v[8] = s[2];
    v[5] = s[1]; v[4] = s[1];
    v[3] = s[0]; v[2] = s[0];
    return v;
  endfunction

  function automatic logic [2:0] dec(input logic [9:0] v);
    return {(v[9] & v[8]) | (v[7] & v[6]),
            (v[7] & v[6]) | (v[5] & v[4]),
            (v[3] & v[2]) | (v[1] & v[0])};
  endfunction

  function automatic void push_frame(input logic [2:0] s, input int hold, input int turn,
                                     input bit inv);
    for (int i = 0; i < hold; i++)
      q.push_back('{1'b1, enc(s), i == hold - 1, s, (i == hold - 1) && !inv});
    if (inv)
      for (int i = 0; i < hold; i++)
        q.push_back('{1'b1, enc(~s), i == hold - 1, ~s, i == hold - 1});
    for (int i = 0; i < turn; i++)
      q.push_back('{1'b0, 10'd0, 1'b0, 3'd0, 1'b0});
  endfunction

  function automatic logic [9:0] jam_mask();
    return jam ? 10'h0C0 : 10'h000;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      exp_frames = 8'd0;
      exp_coll   = 1'b0;
      accepted   = 0;
    end else begin
      exp_coll = 1'b0;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.rb && dec(e.val | jam_mask()) != e.want) exp_coll = 1'b1;
        if (e.last) exp_frames = exp_frames + 8'd1;
      end else if (sym_valid) begin
        push_frame(sym, 2, 1, 1'b1);
        accepted++;
        acc_cyc = cyc;
      end
    end
    if (chk_en && !rst) begin
      #1;
      exp_oe = (q.size() != 0) && q[0].drv;
      check("ready", 32'(sym_ready), 32'(q.size() == 0));
      check("busy", 32'(busy), 32'(q.size() != 0));
      check("oe", 32'(oe), 32'(exp_oe));
      if (exp_oe) check("bus", 32'(a), 32'(q[0].val | jam_mask()));
      check("collision", 32'(collision), 32'(exp_coll));
      check("frames", 32'(frames_sent), 32'(exp_frames));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_accept(input int target);
    int n;
    n = 0;
    while (accepted < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (accepted < target) check("accept_timeout", 32'(accepted), 32'(target));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  logic [9:0] t1_bus[4];
  int         prev_acc;

  initial begin
    #1;
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_ready", 32'(sym_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_coll", 32'(collision), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single 101 frame: true frame, complement frame, turnaround, ready again.
    t1_bus = '{10'h30C, 10'h30C, 10'h030, 10'h030};
    @(negedge clk);
    sym = 3'b101;
    sym_valid = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    sym = 3'b010;
    for (int i = 0; i < 4; i++) begin
      check("t1_oe", 32'(oe), 32'd1);
      check("t1_bus", 32'(a), 32'(t1_bus[i]));
      @(negedge clk);
    end
    check("t1_turn_oe", 32'(oe), 32'd0);
    check("t1_turn_ready", 32'(sym_ready), 32'd0);
    @(negedge clk);
    check("t1_ready", 32'(sym_ready), 32'd1);
    check("t1_frames", 32'(frames_sent), 32'd1);

    // Valid held high, symbols 0..7 back to back.
    sym_valid = 1'b1;
    prev_acc = 0;
    for (int s = 0; s < 8; s++) begin
      sym = 3'(s);
      wait_accept(2 + s);
      if (s > 0) check("step_spacing", 32'(acc_cyc - prev_acc), 32'd6);
      prev_acc = acc_cyc;
    end
    sym_valid = 1'b0;
    drain();
    check("step_frames", 32'(frames_sent), 32'd9);

    // Contention during the true frame of 001.
    sym = 3'b001;
    sym_valid = 1'b1;
    wait_accept(10);
    sym_valid = 1'b0;
    jam = 1'b1;
    @(negedge clk);
    check("jam_pre", 32'(collision), 32'd0);
    @(negedge clk);
    jam = 1'b0;
    check("jam_pulse", 32'(collision), 32'd1);
    @(negedge clk);
    check("jam_clear", 32'(collision), 32'd0);
    drain();
    check("jam_frames", 32'(frames_sent), 32'd10);

    // Asynchronous reset in the middle of the complement frame.
    sym = 3'b110;
    sym_valid = 1'b1;
    wait_accept(11);
    sym_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_oe", 32'(oe), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_oe", 32'(oe), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(sym_ready), 32'd1);
    check("arst_frames", 32'(frames_sent), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic with occasional contention until 256 frames since reset.
    for (int n = 0; n < 6000 && accepted < 256; n++) begin
      @(negedge clk);
      sym = 3'($urandom);
      sym_valid = (($urandom % 4) != 0) && (accepted < 256);
      jam = (($urandom % 8) == 0);
    end
    @(negedge clk);
    sym_valid = 1'b0;
    jam = 1'b0;
    check("rand_accepts", 32'(accepted), 32'd256);
    drain();
    check("wrap_frames", 32'(frames_sent), 32'd0);

    // True frame only, one cycle hold.
    sym2 = 3'b111;
    sym_valid2 = 1'b1;
    @(negedge clk);
    sym_valid2 = 1'b0;
    check("t2_oe", 32'(oe2), 32'd1);
    check("t2_bus", 32'(a2), 32'h33C);
    check("t2_coll0", 32'(collision2), 32'd0);
    @(negedge clk);
    check("t2_turn_oe", 32'(oe2), 32'd0);
    check("t2_turn_busy", 32'(busy2), 32'd1);
    check("t2_coll1", 32'(collision2), 32'd0);
    check("t2_frames", 32'(frames_sent2), 32'd1);
    @(negedge clk);
    check("t2_ready", 32'(sym_ready2), 32'd1);
    check("t2_idle_oe", 32'(oe2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
